// File: rtl/calc_sequencer_if.sv
// Operation request / result bundle between a controller and calc_sequencer.
// The controller side drives start/op/operands; the sequencer returns result and flags.
interface calc_sequencer_if #(
    parameter int DIG = 4
);
    logic              start;
    logic [1:0]        op;
    logic [4*DIG-1:0]  a;
    logic [4*DIG-1:0]  b;
    logic [4*DIG-1:0]  result;
    logic              neg;
    logic              ovf;
    logic              err;
    logic              busy;
    logic              done;

    modport master (
        output start, op, a, b,
        input  result, neg, ovf, err, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output result, neg, ovf, err, busy, done
    );
endinterface

// File: rtl/calc_sequencer.sv
// Digit-serial packed-BCD add/subtract sequencer, one digit per clock, LSD first.
// A negative difference is rerun as B-A after a swap so the result is always a magnitude.
//
//   state  | meaning
//   IDLE   | waiting for start; outputs hold the last result
//   CALC   | processing digit idx_q of the captured operands
//   SWAP   | first subtract pass borrowed out; exchange A/B, mark negative
//   DONE   | publish result, pulse done, drop busy
module calc_sequencer #(
    parameter int DIG = 4
) (
    input  logic           clk,
    input  logic           rst,
    calc_sequencer_if.slave bus
);
    localparam int W  = 4 * DIG;
    localparam int IW = (DIG > 1) ? $clog2(DIG) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_SWAP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [IW-1:0] IDX_LAST = IW'(DIG - 1);

    logic [1:0]    state_q,  state_d;
    logic [W-1:0]  a_q,      a_d;
    logic [W-1:0]  b_q,      b_d;
    logic          sub_q,    sub_d;
    logic [IW-1:0] idx_q,    idx_d;
    logic          cy_q,     cy_d;
    logic [W-1:0]  acc_q,    acc_d;
    logic [W-1:0]  result_q, result_d;
    logic          neg_q,    neg_d;
    logic          ovf_q,    ovf_d;
    logic          err_q,    err_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;

    logic [3:0]    a_dig, b_dig, dig_out;
    logic [4:0]    sum5, dif5;
    logic          cy_next;
    logic          bad_in;

    function automatic logic has_non_bcd(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIG; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_comb begin
        a_dig = a_q[idx_q*4 +: 4];
        b_dig = b_q[idx_q*4 +: 4];
        sum5  = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0, cy_q};
        dif5  = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0, cy_q};
        // A negative 5-bit difference wraps; adding 10 to its low nibble gives d+10 mod 16.
        if (sub_q) begin
            cy_next = dif5[4];
            dig_out = dif5[4] ? (dif5[3:0] + 4'd10) : dif5[3:0];
        end else begin
            cy_next = (sum5 > 5'd9);
            dig_out = (sum5 > 5'd9) ? 4'(sum5 - 5'd10) : sum5[3:0];
        end
        bad_in = has_non_bcd(bus.a) || has_non_bcd(bus.b) || bus.op[1];
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        idx_d    = idx_q;
        cy_d     = cy_q;
        acc_d    = acc_q;
        result_d = result_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    sub_d    = bus.op[0];
                    idx_d    = '0;
                    cy_d     = 1'b0;
                    acc_d    = '0;
                    result_d = '0;
                    neg_d    = 1'b0;
                    ovf_d    = 1'b0;
                    err_d    = bad_in;
                    busy_d   = 1'b1;
                    state_d  = bad_in ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                acc_d[idx_q*4 +: 4] = dig_out;
                cy_d = cy_next;
                if (idx_q == IDX_LAST) begin
                    if (sub_q && cy_next) begin
                        state_d = S_SWAP;
                    end else begin
                        ovf_d   = !sub_q && cy_next;
                        state_d = S_DONE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_SWAP: begin
                a_d     = b_q;
                b_d     = a_q;
                idx_d   = '0;
                cy_d    = 1'b0;
                neg_d   = 1'b1;
                state_d = S_CALC;
            end
            S_DONE: begin
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            idx_q    <= '0;
            cy_q     <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            idx_q    <= idx_d;
            cy_q     <= cy_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.neg    = neg_q;
    assign bus.ovf    = ovf_q;
    assign bus.err    = err_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter: DIG, 4, number of BCD digits per operand and result (each digit 4 bits).
REQ-002 clk  input  1  system clock (the divided slow clock from the top level); all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin an operation; sampled only when busy=0.
REQ-005 op  input  2  operation: 00 add, 01 subtract (A-B), 10/11 reserved.
REQ-006 a  input  4*DIG  operand A, packed BCD, digit 0 in bits [3:0].
REQ-007 b  input  4*DIG  operand B, packed BCD, same layout.
REQ-008 result  output  4*DIG  packed BCD magnitude of the last result.
REQ-009 neg  output  1  result is negative (subtract only).
REQ-010 ovf  output  1  add carried out of the top digit.
REQ-011 err  output  1  operation rejected (non-BCD digit or reserved op).
REQ-012 busy  output  1  operation in progress; start is ignored while high.
REQ-013 done  output  1  one-cycle pulse marking a valid result/flags.

Function
REQ-014 FSM states SHALL be IDLE, CALC, SWAP, DONE; all outputs SHALL be registered.
REQ-015 IDLE: start=1 SHALL capture a, b, op into internal registers, clear result/neg/ovf/err, and set busy=1 on the same edge (call this edge t0).
REQ-016 On t0, if any digit of a or b > 9, or op[1]=1: SHALL go directly to DONE with err=1, result=0; done high in cycle after t0 (t1).
REQ-017 Otherwise: SHALL enter CALC with digit index 0 and carry/borrow 0.
REQ-018 CALC: one digit per clock, LSD first; after digit DIG-1, SHALL leave CALC.
REQ-019 Add digit: s=a_i+b_i+c; if s>9 then digit=s-10, c=1, else digit=s, c=0.
REQ-020 Subtract digit: d=a_i-b_i-br; if d<0 then digit=d+10, br=1, else digit=d, br=0.
REQ-021 Add end: carry out SHALL set ovf=1; result SHALL hold sum mod 10^DIG; go DONE.
REQ-022 Subtract end with br=0: result=A-B, neg=0; go DONE.
REQ-023 Subtract end with br=1: SHALL go SWAP (one cycle: swap captured A/B, clear index and borrow, set neg=1), then rerun CALC as B-A; second pass always ends with br=0, go DONE.
REQ-024 DONE: done=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE.
REQ-025 Latency (start edge t0 to done high): add / non-negative subtract: done high at cycle t0+DIG+1; negative subtract: t0+2*DIG+2; error: t0+1.
REQ-026 start asserted while busy=1 or during DONE SHALL be ignored (no capture, no effect on in-flight op).
REQ-027 start held high continuously SHALL begin a new op in the first IDLE cycle after DONE.
REQ-028 result, neg, ovf, err SHALL hold their values after DONE until the next accepted start.
REQ-029 Changes on a, b, op after t0 SHALL not affect the running operation.
REQ-030 A=B subtract SHALL give result=0, neg=0 (never negative zero).

Reset
REQ-031 rst=0 SHALL immediately force IDLE, result=0, neg=0, ovf=0, err=0, busy=0, done=0, clear internal operand/index/carry registers.
REQ-032 Reset mid-operation SHALL abort it; no done pulse for the aborted op after rst returns high.
REQ-033 First start SHALL be accepted on the first rising edge with rst=1.

Verification
REQ-034 DIG=4, a=0x1234, b=0x4321, op=00, start -> done at t5, result=0x5555, neg=0, ovf=0, err=0.
REQ-035 a=0x9999, b=0x0001, op=00 -> done at t5, result=0x0000, ovf=1.
REQ-036 a=0x0100, b=0x0001, op=01 -> done at t5, result=0x0099, neg=0; then a=0x0001, b=0x0100, op=01 -> done at t10, result=0x0099, neg=1.
REQ-037 a=0x00A0, b=0x0001, op=00 -> done at t1, err=1, result=0; op=10 with valid operands -> same error response.
REQ-038 Start add, pulse start again at t2 with different operands -> ignored, first result unchanged at t5; assert rst=0 at t3 of a new op -> all outputs 0 immediately, no done afterwards.
REQ-039 a=0x4567, b=0x4567, op=01 -> done at t5, result=0x0000, neg=0.
